// File: rtl/wrapping_fifo_if.sv
// wrapping_fifo_if: producer/consumer handshake bundle for wrapping_fifo.
// The level signal exists only when WRAPPING_FIFO_LEVEL_EN is defined.
interface wrapping_fifo_if #(
    parameter int WIDTH = 8
`ifdef WRAPPING_FIFO_LEVEL_EN
    , parameter int LEVEL_WIDTH = 3
`endif
);
    logic             write_enable;
    logic [WIDTH-1:0] write_data;
    logic             full;
    logic             read_enable;
    logic [WIDTH-1:0] read_data;
    logic             empty;
`ifdef WRAPPING_FIFO_LEVEL_EN
    logic [LEVEL_WIDTH-1:0] level;
`endif

    modport master (
        output write_enable, write_data, read_enable,
        input  full, read_data, empty
`ifdef WRAPPING_FIFO_LEVEL_EN
        , input level
`endif
    );

    modport slave (
        input  write_enable, write_data, read_enable,
        output full, read_data, empty
`ifdef WRAPPING_FIFO_LEVEL_EN
        , output level
`endif
    );
endinterface

// File: rtl/wrapping_fifo.sv
// wrapping_fifo: single-clock first-word-fall-through FIFO of any depth >= 2.
// Define WRAPPING_FIFO_LEVEL_EN to expose the occupancy on bus.level.
module wrapping_fifo #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 5,
    parameter int DEPTH_LOG2  = $clog2(DEPTH),
    parameter int LEVEL_WIDTH = $clog2(DEPTH + 1)
) (
    input logic            clock,
    input logic            resetn,
    wrapping_fifo_if.slave bus
);
    logic [WIDTH-1:0]       mem [DEPTH];
    logic [DEPTH_LOG2-1:0]  write_pointer, read_pointer;
    logic [LEVEL_WIDTH-1:0] occupancy;
    logic                   push, pop;

    // A push into a full FIFO is accepted only when the head leaves on the same edge.
    assign push = bus.write_enable && (!bus.full || bus.read_enable);
    assign pop  = bus.read_enable && !bus.empty;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            write_pointer <= '0;
            read_pointer  <= '0;
            occupancy     <= '0;
        end else begin
            if (push)
                write_pointer <= write_pointer == DEPTH_LOG2'(DEPTH - 1) ? '0 : write_pointer + 1'b1;
            if (pop)
                read_pointer <= read_pointer == DEPTH_LOG2'(DEPTH - 1) ? '0 : read_pointer + 1'b1;
            occupancy <= push && !pop ? occupancy + 1'b1 :
                         pop && !push ? occupancy - 1'b1 : occupancy;
        end
    end

    always_ff @(posedge clock) begin
        if (resetn && push)
            mem[write_pointer] <= bus.write_data;
    end

    assign bus.full      = occupancy == LEVEL_WIDTH'(DEPTH);
    assign bus.empty     = occupancy == '0;
    assign bus.read_data = mem[read_pointer];
`ifdef WRAPPING_FIFO_LEVEL_EN
    assign bus.level     = occupancy;
`endif
endmodule

// File: tb/tb_wrapping_fifo.sv
// tb_wrapping_fifo: table-driven check of a DEPTH=5 FIFO plus a DEPTH=4 mid-operation reset sequence.
module tb_wrapping_fifo;
    logic clock = 0;
    logic resetn = 0;
    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

`ifdef WRAPPING_FIFO_LEVEL_EN
    wrapping_fifo_if #(.WIDTH(8), .LEVEL_WIDTH(3)) f5 ();
    wrapping_fifo_if #(.WIDTH(8), .LEVEL_WIDTH(3)) f4 ();
`else
    wrapping_fifo_if #(.WIDTH(8)) f5 ();
    wrapping_fifo_if #(.WIDTH(8)) f4 ();
`endif

    wrapping_fifo #(.WIDTH(8), .DEPTH(5)) dut5 (.clock(clock), .resetn(resetn), .bus(f5));
    wrapping_fifo #(.WIDTH(8), .DEPTH(4)) dut4 (.clock(clock), .resetn(resetn), .bus(f4));

    typedef struct {
        logic       we;
        logic [7:0] wd;
        logic       re;
        int         lvl;
        logic       chk;
        logic [7:0] data;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic we, logic [7:0] wd, logic re, int lvl, logic chk, logic [7:0] data);
        mk.we = we; mk.wd = wd; mk.re = re; mk.lvl = lvl; mk.chk = chk; mk.data = data;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step5(logic we, logic [7:0] wd, logic re);
        f5.write_enable = we; f5.write_data = wd; f5.read_enable = re;
        @(posedge clock);
        #1;
    endtask

    task automatic step4(logic we, logic [7:0] wd, logic re);
        f4.write_enable = we; f4.write_data = wd; f4.read_enable = re;
        @(posedge clock);
        #1;
    endtask

    task automatic check5(string tag, int lvl);
        chk({tag, ".empty"}, int'(f5.empty), int'(lvl == 0));
        chk({tag, ".full"}, int'(f5.full), int'(lvl == 5));
`ifdef WRAPPING_FIFO_LEVEL_EN
        chk({tag, ".level"}, int'(f5.level), lvl);
`endif
    endtask

    initial begin
        f5.write_enable = 0; f5.write_data = 0; f5.read_enable = 0;
        f4.write_enable = 0; f4.write_data = 0; f4.read_enable = 0;

        // fill, overflow attempt, drain, underflow attempt, push+pop on empty
        vq.push_back(mk(1, 8'h11, 0, 1, 1, 8'h11));
        vq.push_back(mk(1, 8'h12, 0, 2, 1, 8'h11));
        vq.push_back(mk(1, 8'h13, 0, 3, 1, 8'h11));
        vq.push_back(mk(1, 8'h14, 0, 4, 1, 8'h11));
        vq.push_back(mk(1, 8'h15, 0, 5, 1, 8'h11));
        vq.push_back(mk(1, 8'hAA, 0, 5, 1, 8'h11));
        vq.push_back(mk(0, 8'h00, 1, 4, 1, 8'h12));
        vq.push_back(mk(0, 8'h00, 1, 3, 1, 8'h13));
        vq.push_back(mk(0, 8'h00, 1, 2, 1, 8'h14));
        vq.push_back(mk(0, 8'h00, 1, 1, 1, 8'h15));
        vq.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00));
        vq.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00));
        vq.push_back(mk(1, 8'hCC, 1, 1, 1, 8'hCC));
        vq.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00));
        // three rounds of push 3 / pop 3 crossing the pointer wrap
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 3; k++)
                vq.push_back(mk(1, 8'(8'h21 + 3 * r + k), 0, k + 1, 1, 8'(8'h21 + 3 * r)));
            for (int k = 0; k < 3; k++)
                vq.push_back(mk(0, 8'h00, 1, 2 - k, k < 2, 8'(8'h22 + 3 * r + k)));
        end
        // full + push 0xBB + pop, then drain; 0xBB must come out last
        for (int k = 0; k < 5; k++)
            vq.push_back(mk(1, 8'(8'h31 + k), 0, k + 1, 1, 8'h31));
        vq.push_back(mk(1, 8'hBB, 1, 5, 1, 8'h32));
        vq.push_back(mk(0, 8'h00, 1, 4, 1, 8'h33));
        vq.push_back(mk(0, 8'h00, 1, 3, 1, 8'h34));
        vq.push_back(mk(0, 8'h00, 1, 2, 1, 8'h35));
        vq.push_back(mk(0, 8'h00, 1, 1, 1, 8'hBB));
        vq.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00));

        resetn = 0;
        repeat (2) @(posedge clock);
        #1;
        resetn = 1;
        check5("reset", 0);
        for (int i = 0; i < 10; i++) begin
            step5(0, 8'h00, 0);
            check5($sformatf("idle%0d", i), 0);
        end

        foreach (vq[i]) begin
            step5(vq[i].we, vq[i].wd, vq[i].re);
            check5($sformatf("vec%0d", i), vq[i].lvl);
            if (vq[i].chk)
                chk($sformatf("vec%0d.data", i), int'(f5.read_data), int'(vq[i].data));
        end
        step5(0, 8'h00, 0);

        // DEPTH=4: reset with three entries stored and a push pending
        step4(1, 8'h41, 0);
        step4(1, 8'h42, 0);
        step4(1, 8'h43, 0);
        chk("d4.pre.empty", int'(f4.empty), 0);
        chk("d4.pre.data", int'(f4.read_data), 8'h41);
`ifdef WRAPPING_FIFO_LEVEL_EN
        chk("d4.pre.level", int'(f4.level), 3);
`endif
        resetn = 0;
        step4(1, 8'h99, 0);
        resetn = 1;
        chk("d4.rst.empty", int'(f4.empty), 1);
        chk("d4.rst.full", int'(f4.full), 0);
`ifdef WRAPPING_FIFO_LEVEL_EN
        chk("d4.rst.level", int'(f4.level), 0);
`endif
        step4(0, 8'h00, 0);
        chk("d4.idle.empty", int'(f4.empty), 1);
        step4(1, 8'h5A, 0);
        chk("d4.push.empty", int'(f4.empty), 0);
        chk("d4.push.data", int'(f4.read_data), 8'h5A);
`ifdef WRAPPING_FIFO_LEVEL_EN
        chk("d4.push.level", int'(f4.level), 1);
`endif
        step4(0, 8'h00, 1);
        chk("d4.pop.empty", int'(f4.empty), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
